// File: rtl/pick_place_pkg.sv
// Shared types and constants for the pick-and-place job sequencer.
package pick_place_pkg;

  localparam int unsigned COORD_W = 32;

  localparam logic [COORD_W-1:0] HOME_X = 32'h0000_0000;
  localparam logic [COORD_W-1:0] HOME_Y = 32'h0019_6666;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_HOME_TBL = 4'd1,
    ST_MOVE_TBL = 4'd2,
    ST_LOWER    = 4'd3,
    ST_GRIP     = 4'd4,
    ST_LIFT     = 4'd5,
    ST_RETURN   = 4'd6,
    ST_PLACE    = 4'd7,
    ST_RELEASE  = 4'd8,
    ST_STOW     = 4'd9,
    ST_CLR      = 4'd10,
    ST_FAULT    = 4'd11
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
  } job_t;

endpackage

// File: rtl/pick_place_sequencer_job_fifo.sv
// Synchronous job FIFO with occupancy count; flush empties it and overrides push/pop.
module job_fifo #(
  parameter int unsigned DW    = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty     = (count_r == LW'(0));
  assign full      = (count_r == LW'(DEPTH));
  assign level     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty && !flush;
  // A full FIFO still takes a write when the head leaves on the same edge.
  assign do_push_s = push && (!full || do_pop_s) && !flush;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= LW'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + LW'(1);
        2'b01:   count_r <= count_r - LW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/pick_place_sequencer.sv
// Pick-and-place job sequencer: queues x/y/z jobs, drives the table and the arm per job,
// waits on table arrival with timeouts, and supports abort and a sticky fault state.
module pick_place_sequencer #(
  parameter int unsigned    W         = pick_place_pkg::COORD_W,
  parameter int unsigned    DEPTH     = 4,
  parameter logic [W-1:0]   HOME_Y    = W'(pick_place_pkg::HOME_Y),
  parameter int unsigned    PULSE_CYC = 20,
  parameter int unsigned    T_LOWER   = 100_000_000,
  parameter int unsigned    T_GRIP    = 200_000_000,
  parameter int unsigned    T_LIFT    = 300_000_000,
  parameter int unsigned    T_TBL_TO  = 750_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [W-1:0]           job_x,
  input  logic [W-1:0]           job_y,
  input  logic [W-1:0]           job_z,
  input  logic                   abort,
  input  logic                   table_home,
  input  logic                   table_at,
  output logic                   table_start_n,
  output logic                   table_back_n,
  output logic [W-1:0]           table_dest,
  output logic [W-1:0]           arm_x,
  output logic [W-1:0]           arm_y,
  output logic                   arm_en1,
  output logic                   arm_en2,
  output logic                   catch,
  output logic                   clr,
  output logic                   busy,
  output logic                   done,
  output logic                   fault,
  output logic [$clog2(DEPTH):0] level
);

  import pick_place_pkg::*;

  localparam int unsigned  LW       = $clog2(DEPTH) + 1;
  localparam logic [W-1:0] HX       = W'(HOME_X);
  localparam logic [W-1:0] T_MAX    = {W{1'b1}};
  localparam logic [W-1:0] PULSE_W  = W'(PULSE_CYC);
  localparam logic [W-1:0] CLR_LAST = W'(PULSE_CYC - 1);
  localparam logic [W-1:0] LOWER_W  = W'(T_LOWER);
  localparam logic [W-1:0] GRIP_W   = W'(T_GRIP);
  localparam logic [W-1:0] LIFT_W   = W'(T_LIFT);
  localparam logic [W-1:0] TO_W     = W'(T_TBL_TO);

  state_e         state_r;
  state_e         state_nxt_s;
  logic [W-1:0]   timer_r;
  logic [W-1:0]   timer_nxt_s;
  logic           aborting_r;
  logic           aborting_nxt_s;
  logic           restart_s;
  logic [W-1:0]   jx_r;
  logic [W-1:0]   jy_r;
  logic [W-1:0]   jz_r;

  logic           push_s;
  logic           pop_s;
  logic           flush_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic [3*W-1:0] fifo_rdata_s;
  logic [LW-1:0]  fifo_level_s;

  logic [W-1:0]   arm_x_nxt_s;
  logic [W-1:0]   arm_y_nxt_s;
  logic [W-1:0]   dest_nxt_s;
  logic           en1_nxt_s;
  logic           en2_nxt_s;
  logic           catch_nxt_s;
  logic           start_n_nxt_s;
  logic           back_n_nxt_s;
  logic           clr_nxt_s;
  logic           done_nxt_s;

  assign job_ready = !fifo_full_s;
  assign level     = fifo_level_s;
  assign push_s    = job_valid && job_ready;
  assign pop_s     = (state_r == ST_IDLE) && (state_nxt_s == ST_HOME_TBL);
  // Abort beats a simultaneous push; the queue is also held empty while faulted.
  assign flush_s   = abort || (state_nxt_s == ST_FAULT);

  job_fifo #(
    .DW    (3 * W),
    .DEPTH (DEPTH)
  ) u_job_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_s),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({job_x, job_y, job_z}),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level_s)
  );

  // Next-state, abort handling and shared timer update.
  always_comb begin
    state_nxt_s    = state_r;
    aborting_nxt_s = aborting_r;
    restart_s      = 1'b0;
    if (abort && (state_r != ST_IDLE) && (state_r != ST_FAULT) && !aborting_r) begin
      state_nxt_s    = ST_RETURN;
      aborting_nxt_s = 1'b1;
      restart_s      = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!abort && !fifo_empty_s) state_nxt_s = ST_HOME_TBL;
          else                         state_nxt_s = ST_IDLE;
        end
        ST_HOME_TBL: begin
          if (table_home && (timer_r >= PULSE_W)) begin
            if (jz_r == W'(0)) state_nxt_s = ST_LOWER;
            else               state_nxt_s = ST_MOVE_TBL;
          end else if (timer_r >= TO_W) begin
            state_nxt_s = ST_FAULT;
          end else begin
            state_nxt_s = ST_HOME_TBL;
          end
        end
        ST_MOVE_TBL: begin
          if (table_at && (timer_r >= PULSE_W)) state_nxt_s = ST_LOWER;
          else if (timer_r >= TO_W)             state_nxt_s = ST_FAULT;
          else                                  state_nxt_s = ST_MOVE_TBL;
        end
        ST_LOWER: begin
          if (timer_r >= LOWER_W) state_nxt_s = ST_GRIP;
          else                    state_nxt_s = ST_LOWER;
        end
        ST_GRIP: begin
          if (timer_r >= GRIP_W) state_nxt_s = ST_LIFT;
          else                   state_nxt_s = ST_GRIP;
        end
        ST_LIFT: begin
          if (timer_r >= LIFT_W) state_nxt_s = ST_RETURN;
          else                   state_nxt_s = ST_LIFT;
        end
        ST_RETURN: begin
          if (table_home && (timer_r >= PULSE_W)) begin
            if (aborting_r) state_nxt_s = ST_IDLE;
            else            state_nxt_s = ST_PLACE;
          end else if (timer_r >= TO_W) begin
            state_nxt_s = ST_FAULT;
          end else begin
            state_nxt_s = ST_RETURN;
          end
        end
        ST_PLACE: begin
          if (timer_r >= LOWER_W) state_nxt_s = ST_RELEASE;
          else                    state_nxt_s = ST_PLACE;
        end
        ST_RELEASE: begin
          if (timer_r >= GRIP_W) state_nxt_s = ST_STOW;
          else                   state_nxt_s = ST_RELEASE;
        end
        ST_STOW: begin
          if (timer_r >= LIFT_W) state_nxt_s = ST_CLR;
          else                   state_nxt_s = ST_STOW;
        end
        ST_CLR: begin
          if (timer_r >= CLR_LAST) state_nxt_s = ST_IDLE;
          else                     state_nxt_s = ST_CLR;
        end
        ST_FAULT: begin
          if (abort) state_nxt_s = ST_IDLE;
          else       state_nxt_s = ST_FAULT;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end

    if ((state_nxt_s == ST_IDLE) || (state_nxt_s == ST_FAULT)) aborting_nxt_s = 1'b0;
    else                                                       aborting_nxt_s = aborting_nxt_s;

    if ((state_nxt_s != state_r) || restart_s) timer_nxt_s = W'(0);
    else if (timer_r == T_MAX)                 timer_nxt_s = timer_r;
    else                                       timer_nxt_s = timer_r + W'(1);
  end

  // Output values for the state being entered, so registered outputs line up with the state.
  always_comb begin
    arm_x_nxt_s   = HX;
    arm_y_nxt_s   = HOME_Y;
    en1_nxt_s     = 1'b0;
    en2_nxt_s     = 1'b1;
    catch_nxt_s   = 1'b0;
    start_n_nxt_s = 1'b1;
    back_n_nxt_s  = 1'b1;
    clr_nxt_s     = 1'b0;
    done_nxt_s    = 1'b0;
    case (state_nxt_s)
      ST_HOME_TBL: begin
        if (timer_nxt_s < PULSE_W) back_n_nxt_s = 1'b0;
        else                       back_n_nxt_s = 1'b1;
      end
      ST_MOVE_TBL: begin
        if (timer_nxt_s < PULSE_W) start_n_nxt_s = 1'b0;
        else                       start_n_nxt_s = 1'b1;
      end
      ST_LOWER, ST_GRIP, ST_PLACE, ST_RELEASE: begin
        arm_x_nxt_s = jx_r;
        arm_y_nxt_s = jy_r;
        en1_nxt_s   = 1'b1;
        en2_nxt_s   = 1'b0;
        catch_nxt_s = (state_nxt_s == ST_GRIP) || (state_nxt_s == ST_PLACE);
      end
      ST_LIFT: begin
        catch_nxt_s = 1'b1;
      end
      ST_RETURN: begin
        // The part rides home in the gripper unless the job was abandoned.
        catch_nxt_s = !aborting_nxt_s;
        if (timer_nxt_s < PULSE_W) back_n_nxt_s = 1'b0;
        else                       back_n_nxt_s = 1'b1;
      end
      ST_CLR: begin
        clr_nxt_s  = 1'b1;
        done_nxt_s = (timer_nxt_s == CLR_LAST);
      end
      default: begin
        catch_nxt_s = 1'b0;
      end
    endcase

    if ((state_r == ST_HOME_TBL) && ((state_nxt_s == ST_MOVE_TBL) || (state_nxt_s == ST_LOWER))) begin
      dest_nxt_s = jz_r;
    end else begin
      dest_nxt_s = table_dest;
    end
  end

  // State, timer and abort flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      timer_r    <= W'(0);
      aborting_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      timer_r    <= timer_nxt_s;
      aborting_r <= aborting_nxt_s;
    end
  end

  // Current job latched as it leaves the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      jx_r <= W'(0);
      jy_r <= W'(0);
      jz_r <= W'(0);
    end else if (pop_s) begin
      {jx_r, jy_r, jz_r} <= fifo_rdata_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      arm_x         <= HX;
      arm_y         <= HOME_Y;
      arm_en1       <= 1'b0;
      arm_en2       <= 1'b1;
      catch         <= 1'b0;
      table_start_n <= 1'b1;
      table_back_n  <= 1'b1;
      table_dest    <= W'(0);
      clr           <= 1'b0;
      done          <= 1'b0;
      fault         <= 1'b0;
      busy          <= 1'b0;
    end else begin
      arm_x         <= arm_x_nxt_s;
      arm_y         <= arm_y_nxt_s;
      arm_en1       <= en1_nxt_s;
      arm_en2       <= en2_nxt_s;
      catch         <= catch_nxt_s;
      table_start_n <= start_n_nxt_s;
      table_back_n  <= back_n_nxt_s;
      table_dest    <= dest_nxt_s;
      clr           <= clr_nxt_s;
      done          <= done_nxt_s;
      fault         <= (state_nxt_s == ST_FAULT);
      busy          <= (state_nxt_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_pick_place_sequencer.sv
// Scoreboard bench: accepted jobs are queued as expectations, a monitor checks each completion.
module tb_pick_place_sequencer;

  localparam int          PULSE   = 4;
  localparam int          TBL_DLY = 20;
  localparam logic [31:0] HOME_Y  = 32'h0019_6666;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_x, job_y, job_z;
  logic        abort;
  logic        table_home, table_at;
  logic        table_start_n, table_back_n;
  logic [31:0] table_dest, arm_x, arm_y;
  logic        arm_en1, arm_en2, catch, clr, busy, done, fault;
  logic [2:0]  level;

  int compared   = 0;
  int mismatched = 0;
  int done_cnt   = 0;
  int clr_pulses = 0;
  int back_pulses = 0;
  bit at_stuck   = 1'b0;
  logic [31:0] cap_x = 32'd0;
  logic [31:0] cap_y = 32'd0;
  pick_place_pkg::job_t exp_q[$];

  pick_place_sequencer #(
    .W(32), .DEPTH(4), .HOME_Y(32'h0019_6666), .PULSE_CYC(4),
    .T_LOWER(20), .T_GRIP(15), .T_LIFT(10), .T_TBL_TO(100)
  ) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_x(job_x), .job_y(job_y), .job_z(job_z), .abort(abort),
    .table_home(table_home), .table_at(table_at),
    .table_start_n(table_start_n), .table_back_n(table_back_n), .table_dest(table_dest),
    .arm_x(arm_x), .arm_y(arm_y), .arm_en1(arm_en1), .arm_en2(arm_en2),
    .catch(catch), .clr(clr), .busy(busy), .done(done), .fault(fault), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic sig_of(input int which);
    case (which)
      0:       return catch;
      1:       return arm_en1;
      2:       return busy;
      3:       return fault;
      4:       return table_start_n;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic val, input int budget, input string nm);
    for (int n = 0; n < budget; n++) begin
      if (sig_of(which) === val) return;
      @(negedge clk);
    end
    if (sig_of(which) !== val) begin
      compared++;
      mismatched++;
      $display("FAIL timeout %s: still %0b after %0d cycles", nm, sig_of(which), budget);
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done count reached", done_cnt, target);
  endtask

  task automatic push_job(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    pick_place_pkg::job_t j;
    int n = 0;
    while (!job_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!job_ready) begin
      compared++;
      mismatched++;
      $display("FAIL push: job_ready stayed 0 for %0d cycles", n);
    end else begin
      job_x = x; job_y = y; job_z = z; job_valid = 1'b1;
      j.x = x; j.y = y; j.z = z;
      exp_q.push_back(j);
      @(negedge clk);
      job_valid = 1'b0;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " arm_x"}, arm_x, 32'd0);
    chk({tag, " arm_y"}, arm_y, HOME_Y);
    chk({tag, " en1"}, arm_en1, 32'd0);
    chk({tag, " en2"}, arm_en2, 32'd1);
    chk({tag, " catch"}, catch, 32'd0);
    chk({tag, " start_n"}, table_start_n, 32'd1);
    chk({tag, " back_n"}, table_back_n, 32'd1);
    chk({tag, " dest"}, table_dest, 32'd0);
    chk({tag, " clr"}, clr, 32'd0);
    chk({tag, " done"}, done, 32'd0);
    chk({tag, " fault"}, fault, 32'd0);
    chk({tag, " busy"}, busy, 32'd0);
    chk({tag, " job_ready"}, job_ready, 32'd1);
    chk({tag, " level"}, level, 32'd0);
  endtask

  // Table emulator: reaches home / destination TBL_DLY cycles after the respective pulse.
  initial begin
    int home_cnt;
    int at_cnt;
    home_cnt = 0;
    at_cnt = 0;
    table_home = 1'b1;
    table_at = 1'b0;
    forever begin
      @(negedge clk);
      if (!table_back_n) begin
        table_home = 1'b0; table_at = 1'b0; home_cnt = TBL_DLY;
      end else if (home_cnt > 0) begin
        home_cnt--;
        if (home_cnt == 0) table_home = 1'b1;
      end
      if (!table_start_n) begin
        table_home = 1'b0; table_at = 1'b0; at_cnt = at_stuck ? 0 : TBL_DLY;
      end else if (at_cnt > 0) begin
        at_cnt--;
        if (at_cnt == 0) table_at = 1'b1;
      end
    end
  end

  // Monitor: pulse widths, pulse exclusivity, and completed jobs against the scoreboard.
  initial begin
    int back_run, start_run, clr_run, done_run;
    logic prev_catch, prev_done;
    pick_place_pkg::job_t j;
    back_run = 0; start_run = 0; clr_run = 0; done_run = 0;
    prev_catch = 1'b0; prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        back_run = 0; start_run = 0; clr_run = 0; done_run = 0;
        prev_catch = 1'b0; prev_done = 1'b0;
      end else begin
        if (!table_back_n) back_run++;
        else if (back_run != 0) begin chk("back_n width", back_run, PULSE); back_run = 0; back_pulses++; end
        if (!table_start_n) start_run++;
        else if (start_run != 0) begin chk("start_n width", start_run, PULSE); start_run = 0; end
        if (clr) clr_run++;
        else if (clr_run != 0) begin chk("clr width", clr_run, PULSE); clr_run = 0; clr_pulses++; end
        if (done) done_run++;
        else if (done_run != 0) begin chk("done width", done_run, 1); done_run = 0; end
        if (!table_start_n || !table_back_n) chk("start/back overlap", table_start_n | table_back_n, 1);
        if (catch && !prev_catch) begin cap_x = arm_x; cap_y = arm_y; end
        if (done && !prev_done) begin
          done_cnt++;
          chk("done on last clr cycle", clr_run, PULSE);
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL done: completion with no job expected");
          end else begin
            j = exp_q.pop_front();
            chk("job z (table_dest)", table_dest, j.z);
            chk("job x at grip", cap_x, j.x);
            chk("job y at grip", cap_y, j.y);
          end
        end
        prev_catch = catch;
        prev_done = done;
      end
    end
  end

  initial begin
    int base, accepted, n, b0, c0, d0;
    logic ready5;
    rst = 1'b1; job_valid = 1'b0; job_x = 32'd0; job_y = 32'd0; job_z = 32'd0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("idle");

    // Single job with full table moves.
    base = done_cnt;
    push_job(32'h0008_0000, 32'h000A_0000, 32'd500);
    wait_done(base + 1, 800);
    @(negedge clk);
    chk("busy after job", busy, 32'd0);

    // Five back-to-back pushes while busy: only four fit.
    base = done_cnt;
    push_job(32'h0001_0000, 32'h0002_0000, 32'd11);
    repeat (3) @(negedge clk);
    accepted = 0;
    ready5 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      job_x = 32'h100 + i; job_y = 32'h200 + i; job_z = 32'd20 + i; job_valid = 1'b1;
      if (i == 4) ready5 = job_ready;
      if (job_ready) begin
        pick_place_pkg::job_t j;
        j.x = job_x; j.y = job_y; j.z = job_z;
        exp_q.push_back(j);
        accepted++;
      end
      @(negedge clk);
    end
    job_valid = 1'b0;
    chk("accepted of five", accepted, 4);
    chk("job_ready on fifth", ready5, 32'd0);
    chk("level when full", level, 32'd4);
    wait_done(base + 5, 2500);

    // Randomised jobs, some with z = 0 (no table move).
    base = done_cnt;
    for (int i = 0; i < 8; i++) begin
      push_job($urandom, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000)));
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    wait_done(base + 8, 4000);
    chk("scoreboard drained", exp_q.size(), 32'd0);

    // Table never arrives: fault, queue flushed, abort recovers.
    at_stuck = 1'b1;
    push_job(32'h10, 32'h20, 32'd77);
    push_job(32'h30, 32'h40, 32'd88);
    wait_for(4, 1'b0, 300, "start pulse");
    n = 0;
    while (!fault && n < 300) begin @(negedge clk); n++; end
    chk("fault latency from start pulse", n, 101);
    chk("fault flag", fault, 32'd1);
    chk("catch in fault", catch, 32'd0);
    chk("level in fault", level, 32'd0);
    exp_q.delete();
    at_stuck = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("busy after fault abort", busy, 32'd0);
    chk("fault after abort", fault, 32'd0);

    // Abort during GRIP with two jobs queued.
    push_job(32'h1234, 32'h5678, 32'd300);
    push_job(32'h1111, 32'h2222, 32'd301);
    push_job(32'h3333, 32'h4444, 32'd302);
    wait_for(0, 1'b1, 400, "grip");
    chk("level before abort", level, 32'd2);
    b0 = back_pulses; c0 = clr_pulses; d0 = done_cnt;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    exp_q.delete();
    chk("catch after abort", catch, 32'd0);
    chk("level after abort", level, 32'd0);
    wait_for(2, 1'b0, 300, "idle after abort");
    @(negedge clk);
    chk("back pulses on abort", back_pulses - b0, 32'd1);
    chk("clr pulses on abort", clr_pulses - c0, 32'd0);
    chk("done pulses on abort", done_cnt - d0, 32'd0);

    // Reset while placing.
    push_job(32'hABCD, 32'hDCBA, 32'd42);
    wait_for(0, 1'b1, 400, "grip before place");
    wait_for(1, 1'b0, 200, "lift");
    wait_for(1, 1'b1, 300, "place");
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk_reset("reset in place");
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (40) @(negedge clk);
    chk("no done after reset", done_cnt - d0, 32'd0);
    chk("idle after reset", busy, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
